// File: rtl/alu_pipeline_v2.sv
// Four-stage integer ALU pipe (issue -> operand collect -> execute -> writeback)
// with per-stage valid registers and ready/valid back-pressure from the PRF.
module alu_pipeline_v2 #(
  parameter int  PRF_BANK_COUNT     = 4,
  parameter int  PR_COUNT           = 64,
  parameter int  ROB_ENTRIES        = 64,
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT),
  localparam int LOG_PR_COUNT       = $clog2(PR_COUNT),
  localparam int LOG_ROB_ENTRIES    = $clog2(ROB_ENTRIES)
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 issue_valid,
  input  logic [3:0]                           issue_op,
  input  logic                                 issue_is_imm,
  input  logic [31:0]                          issue_imm,
  input  logic                                 issue_A_unneeded,
  input  logic                                 issue_A_forward,
  input  logic                                 issue_B_forward,
  input  logic [LOG_PRF_BANK_COUNT-1:0]        issue_A_bank,
  input  logic [LOG_PRF_BANK_COUNT-1:0]        issue_B_bank,
  input  logic [LOG_PR_COUNT-1:0]              issue_dest_PR,
  input  logic [LOG_ROB_ENTRIES-1:0]           issue_ROB_index,
  input  logic                                 A_reg_read_valid,
  input  logic                                 B_reg_read_valid,
  input  logic [PRF_BANK_COUNT-1:0][31:0]      reg_read_data_by_bank,
  input  logic [PRF_BANK_COUNT-1:0][31:0]      forward_data_by_bank,
  output logic                                 issue_ready,
  output logic                                 WB_valid,
  output logic [31:0]                          WB_data,
  output logic [LOG_PR_COUNT-1:0]              WB_PR,
  output logic [LOG_ROB_ENTRIES-1:0]           WB_ROB_index,
  input  logic                                 WB_ready
);

  typedef struct packed {
    logic [3:0]                    op;
    logic                          is_imm;
    logic [31:0]                   imm;
    logic                          a_unneeded;
    logic                          a_fwd;
    logic                          b_fwd;
    logic [LOG_PRF_BANK_COUNT-1:0] a_bank;
    logic [LOG_PRF_BANK_COUNT-1:0] b_bank;
    logic [LOG_PR_COUNT-1:0]       pr;
    logic [LOG_ROB_ENTRIES-1:0]    rob;
  } oc_op_t;

  oc_op_t                     oc;
  logic                       oc_valid, oc_first, a_saved, b_saved;
  logic [31:0]                a_val, b_val;
  logic                       ex_valid;
  logic [3:0]                 ex_op;
  logic [31:0]                ex_a, ex_b, ex_res;
  logic [LOG_PR_COUNT-1:0]    ex_pr;
  logic [LOG_ROB_ENTRIES-1:0] ex_rob;

  logic        a_need, b_need, a_arrive, b_arrive, a_ok, b_ok;
  logic [31:0] a_in, b_in, a_opnd, b_opnd;
  logic        wb_adv, ex_accept, oc_adv;
  logic [4:0]  shamt;

  // A forwarded operand is only on the forward bus during the first OC cycle.
  assign a_need   = !oc.a_unneeded;
  assign b_need   = !oc.is_imm;
  assign a_arrive = oc.a_fwd ? oc_first : A_reg_read_valid;
  assign b_arrive = oc.b_fwd ? oc_first : B_reg_read_valid;
  assign a_in     = oc.a_fwd ? forward_data_by_bank[oc.a_bank] : reg_read_data_by_bank[oc.a_bank];
  assign b_in     = oc.b_fwd ? forward_data_by_bank[oc.b_bank] : reg_read_data_by_bank[oc.b_bank];
  assign a_ok     = !a_need || a_saved || a_arrive;
  assign b_ok     = !b_need || b_saved || b_arrive;
  assign a_opnd   = !a_need ? 32'd0 : (a_saved ? a_val : a_in);
  assign b_opnd   = oc.is_imm ? oc.imm : (b_saved ? b_val : b_in);

  assign wb_adv      = !WB_valid || WB_ready;
  assign ex_accept   = !ex_valid || wb_adv;
  assign oc_adv      = oc_valid && a_ok && b_ok && ex_accept;
  assign issue_ready = !oc_valid || oc_adv;

  assign shamt = ex_b[4:0];

  always_comb begin
    ex_res = '0;
    case (ex_op)
      4'b1000: ex_res = ex_a - ex_b;
      4'b1101: ex_res = $unsigned($signed(ex_a) >>> shamt);
      4'b1111: ex_res = ex_b;
      default: begin
        case (ex_op[2:0])
          3'd0: ex_res = ex_a + ex_b;
          3'd1: ex_res = ex_a << shamt;
          3'd2: ex_res = {31'd0, $signed(ex_a) < $signed(ex_b)};
          3'd3: ex_res = {31'd0, ex_a < ex_b};
          3'd4: ex_res = ex_a ^ ex_b;
          3'd5: ex_res = ex_a >> shamt;
          3'd6: ex_res = ex_a | ex_b;
          default: ex_res = ex_a & ex_b;
        endcase
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      oc_valid     <= 1'b0;
      oc_first     <= 1'b0;
      a_saved      <= 1'b0;
      b_saved      <= 1'b0;
      ex_valid     <= 1'b0;
      WB_valid     <= 1'b0;
      WB_data      <= '0;
      WB_PR        <= '0;
      WB_ROB_index <= '0;
    end else begin
      if (issue_ready) begin
        oc_valid <= issue_valid;
        oc_first <= 1'b1;
        a_saved  <= 1'b0;
        b_saved  <= 1'b0;
        oc       <= '{op: issue_op, is_imm: issue_is_imm, imm: issue_imm,
                      a_unneeded: issue_A_unneeded, a_fwd: issue_A_forward,
                      b_fwd: issue_B_forward, a_bank: issue_A_bank,
                      b_bank: issue_B_bank, pr: issue_dest_PR, rob: issue_ROB_index};
      end else begin
        // Stalled in OC: latch whatever operands showed up this cycle.
        oc_first <= 1'b0;
        if (a_need && !a_saved && a_arrive) begin
          a_saved <= 1'b1;
          a_val   <= a_in;
        end
        if (b_need && !b_saved && b_arrive) begin
          b_saved <= 1'b1;
          b_val   <= b_in;
        end
      end
      if (ex_accept) begin
        ex_valid <= oc_adv;
        if (oc_adv) begin
          ex_op  <= oc.op;
          ex_a   <= a_opnd;
          ex_b   <= b_opnd;
          ex_pr  <= oc.pr;
          ex_rob <= oc.rob;
        end
      end
      if (wb_adv) begin
        WB_valid <= ex_valid;
        if (ex_valid) begin
          WB_data      <= ex_res;
          WB_PR        <= ex_pr;
          WB_ROB_index <= ex_rob;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipeline_v2.sv
// Bench for alu_pipeline_v2: directed scenarios plus random traffic scored
// against an in-order queue of results computed from the op definitions.
module tb_alu_pipeline_v2;
  localparam int NB = 4;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 issue_valid, issue_is_imm, issue_A_unneeded, issue_A_forward, issue_B_forward;
  logic [3:0]           issue_op;
  logic [31:0]          issue_imm;
  logic [1:0]           issue_A_bank, issue_B_bank;
  logic [5:0]           issue_dest_PR, issue_ROB_index;
  logic                 A_reg_read_valid, B_reg_read_valid;
  logic [NB-1:0][31:0]  reg_read_data_by_bank, forward_data_by_bank;
  logic                 issue_ready, WB_valid, WB_ready;
  logic [31:0]          WB_data;
  logic [5:0]           WB_PR, WB_ROB_index;

  always #5 CLK = ~CLK;

  alu_pipeline_v2 dut (
    .CLK(CLK), .RST(RST), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_is_imm(issue_is_imm), .issue_imm(issue_imm), .issue_A_unneeded(issue_A_unneeded),
    .issue_A_forward(issue_A_forward), .issue_B_forward(issue_B_forward),
    .issue_A_bank(issue_A_bank), .issue_B_bank(issue_B_bank), .issue_dest_PR(issue_dest_PR),
    .issue_ROB_index(issue_ROB_index), .A_reg_read_valid(A_reg_read_valid),
    .B_reg_read_valid(B_reg_read_valid), .reg_read_data_by_bank(reg_read_data_by_bank),
    .forward_data_by_bank(forward_data_by_bank), .issue_ready(issue_ready),
    .WB_valid(WB_valid), .WB_data(WB_data), .WB_PR(WB_PR), .WB_ROB_index(WB_ROB_index),
    .WB_ready(WB_ready)
  );

  typedef struct {
    logic [3:0]  op;
    logic        imm;
    logic [31:0] immv;
    logic        aun, afwd, bfwd;
    logic [1:0]  ab, bb;
    logic [5:0]  pr, rob;
    logic [31:0] a, b;
  } op_t;
  typedef struct {
    logic [31:0] d;
    logic [5:0]  pr, rob;
  } exp_t;

  exp_t        expq[$];
  op_t         nx, cur, o1, o2, o3, o4;
  bit          have_nx, cur_first, rrv_a, rrv_b, hold_pend;
  int          total, bad;
  logic [31:0] last_data, hd;
  logic [5:0]  hpr, hrob;

  function automatic logic [31:0] ref_alu(op_t o);
    logic [31:0] a, b;
    int          sh;
    a  = o.aun ? 32'd0 : o.a;
    b  = o.imm ? o.immv : o.b;
    sh = int'(b[4:0]);
    if (o.op == 4'd8)  return a - b;
    if (o.op == 4'd15) return b;
    if (o.op == 4'd13) return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
    case (o.op[2:0])
      3'd0: return a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic op_t mk(logic [3:0] op, logic imm, logic [31:0] immv, logic aun,
                             logic afwd, logic bfwd, logic [1:0] ab, logic [1:0] bb,
                             logic [5:0] pr, logic [5:0] rob, logic [31:0] a, logic [31:0] b);
    op_t o;
    o.op = op; o.imm = imm; o.immv = immv; o.aun = aun; o.afwd = afwd; o.bfwd = bfwd;
    o.ab = ab; o.bb = bb; o.pr = pr; o.rob = rob; o.a = a; o.b = b;
    return o;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic op_t rand_op();
    logic [1:0] ab;
    ab = 2'($urandom_range(0, 3));
    return mk(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), rnd_val(),
              $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ab, ab + 2'($urandom_range(1, 3)), 6'($urandom), 6'($urandom), rnd_val(), rnd_val());
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive buses for the op believed to sit in OC, score WB, advance.
  task automatic step();
    bit   acc, fire;
    exp_t e;
    for (int i = 0; i < NB; i++) begin
      reg_read_data_by_bank[i] = $urandom;
      forward_data_by_bank[i]  = $urandom;
    end
    A_reg_read_valid = rrv_a;
    B_reg_read_valid = rrv_b;
    if (!cur.afwd && rrv_a) reg_read_data_by_bank[cur.ab] = cur.a;
    if (!cur.bfwd && rrv_b) reg_read_data_by_bank[cur.bb] = cur.b;
    if (cur_first && cur.afwd) forward_data_by_bank[cur.ab] = cur.a;
    if (cur_first && cur.bfwd) forward_data_by_bank[cur.bb] = cur.b;
    issue_valid = have_nx;     issue_op = nx.op;          issue_is_imm = nx.imm;
    issue_imm = nx.immv;       issue_A_unneeded = nx.aun; issue_A_forward = nx.afwd;
    issue_B_forward = nx.bfwd; issue_A_bank = nx.ab;      issue_B_bank = nx.bb;
    issue_dest_PR = nx.pr;     issue_ROB_index = nx.rob;
    #1;
    if (hold_pend) begin
      chk("hold_valid", 32'(WB_valid), 32'd1);
      chk("hold_data", WB_data, hd);
      chk("hold_pr", 32'(WB_PR), 32'(hpr));
      chk("hold_rob", 32'(WB_ROB_index), 32'(hrob));
    end
    acc  = issue_valid && issue_ready;
    fire = WB_valid && WB_ready;
    if (fire) begin
      if (expq.size() == 0) chk("spurious_wb", 32'(WB_valid), 32'd0);
      else begin
        e = expq.pop_front();
        chk("wb_data", WB_data, e.d);
        chk("wb_pr", 32'(WB_PR), 32'(e.pr));
        chk("wb_rob", 32'(WB_ROB_index), 32'(e.rob));
        last_data = WB_data;
      end
    end
    hold_pend = WB_valid && !WB_ready && !RST;
    hd = WB_data; hpr = WB_PR; hrob = WB_ROB_index;
    @(posedge CLK);
    if (RST) begin
      expq.delete();
      have_nx   = 0;
      cur_first = 0;
    end else if (acc) begin
      expq.push_back('{ref_alu(nx), nx.pr, nx.rob});
      cur       = nx;
      cur_first = 1;
      have_nx   = 0;
    end else cur_first = 0;
    @(negedge CLK);
  endtask

  task automatic wait_accept();
    for (int k = 0; k < 50 && have_nx; k++) step();
    if (have_nx) begin
      chk("issue_timeout", 32'(issue_ready), 32'd1);
      have_nx = 0;
    end
  endtask

  task automatic send(op_t o);
    nx = o;
    have_nx = 1;
    wait_accept();
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && expq.size() > 0; k++) step();
    chk("drain_left", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; have_nx = 0; cur_first = 0; hold_pend = 0; last_data = '0;
    rrv_a = 1; rrv_b = 1; WB_ready = 1; RST = 1;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    nx  = cur;
    @(negedge CLK);
    step(); step();
    RST = 0;
    chk("rst_ready", 32'(issue_ready), 32'd1);
    chk("rst_wb_valid", 32'(WB_valid), 32'd0);
    chk("rst_wb_data", WB_data, 32'd0);
    chk("rst_wb_pr", 32'(WB_PR), 32'd0);
    chk("rst_wb_rob", 32'(WB_ROB_index), 32'd0);
    repeat (3) step();
    chk("nop_wb_valid", 32'(WB_valid), 32'd0);

    // ADD p2 then back-to-back SLLI p4; fixed two-cycle latency
    send(mk(4'd0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 6'd2, 6'd0, 32'd1, 32'd0));
    send(mk(4'd1, 1, 32'd4, 0, 0, 0, 2'd3, 2'd0, 6'd4, 6'd1, 32'd3, 32'd0));
    step();
    chk("add_valid", 32'(WB_valid), 32'd1);
    chk("add_data", WB_data, 32'd1);
    chk("add_pr", 32'(WB_PR), 32'd2);
    chk("add_rob", 32'(WB_ROB_index), 32'd0);
    step();
    chk("slli_valid", 32'(WB_valid), 32'd1);
    chk("slli_data", WB_data, 32'h30);
    chk("slli_pr", 32'(WB_PR), 32'd4);
    chk("slli_rob", 32'(WB_ROB_index), 32'd1);
    drain();

    // SLT / SLTU with forwarded A = -1 and read B = 0
    send(mk(4'd2, 0, 0, 0, 1, 0, 2'd1, 2'd2, 6'd7, 6'd2, 32'hFFFF_FFFF, 32'd0));
    drain();
    chk("slt_data", last_data, 32'd1);
    send(mk(4'd3, 0, 0, 0, 1, 0, 2'd1, 2'd2, 6'd7, 6'd3, 32'hFFFF_FFFF, 32'd0));
    drain();
    chk("sltu_data", last_data, 32'd0);

    // B read withheld two cycles while a second op waits
    rrv_b = 0;
    send(mk(4'd0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 6'd9, 6'd4, 32'd5, 32'd7));
    nx = mk(4'd4, 1, 32'h0F0F, 0, 0, 0, 2'd2, 2'd3, 6'd10, 6'd5, 32'h00FF, 32'd0);
    have_nx = 1;
    step();
    rrv_a = 0;
    chk("stall_ready_1", 32'(issue_ready), 32'd0);
    step();
    chk("stall_ready_2", 32'(issue_ready), 32'd0);
    rrv_a = 1; rrv_b = 1;
    wait_accept();
    drain();
    chk("stall_xor_data", last_data, 32'h0FF0);

    // WB held three cycles with three ops in flight
    WB_ready = 0;
    o1 = mk(4'd8, 0, 0, 0, 0, 0, 2'd0, 2'd1, 6'd11, 6'd6, 32'd10, 32'd3);
    o2 = mk(4'd13, 1, 32'd4, 0, 0, 0, 2'd2, 2'd0, 6'd12, 6'd7, 32'h8000_0000, 32'd0);
    o3 = mk(4'd15, 1, 32'hABCD, 1, 0, 0, 2'd1, 2'd3, 6'd13, 6'd8, 32'd0, 32'd0);
    o4 = mk(4'd6, 0, 0, 0, 0, 1, 2'd3, 2'd2, 6'd14, 6'd9, 32'h0F, 32'hF0);
    send(o1); send(o2); send(o3);
    nx = o4;
    have_nx = 1;
    repeat (3) step();
    chk("bp_ready", 32'(issue_ready), 32'd0);
    chk("bp_wb_valid", 32'(WB_valid), 32'd1);
    chk("bp_wb_rob", 32'(WB_ROB_index), 32'd6);
    WB_ready = 1;
    wait_accept();
    drain();
    chk("bp_last", last_data, 32'hFF);

    // random traffic with random stalls on both sides
    for (int c = 0; c < 500; c++) begin
      WB_ready = $urandom_range(0, 3) != 0;
      rrv_a    = $urandom_range(0, 2) != 0;
      rrv_b    = $urandom_range(0, 2) != 0;
      if (!have_nx && $urandom_range(0, 3) != 0) begin
        nx = rand_op();
        have_nx = 1;
      end
      step();
    end
    WB_ready = 1; rrv_a = 1; rrv_b = 1;
    wait_accept();
    drain();

    // reset with ops in flight discards them
    send(rand_op());
    send(rand_op());
    RST = 1;
    step();
    RST = 0;
    chk("mid_rst_valid", 32'(WB_valid), 32'd0);
    chk("mid_rst_data", WB_data, 32'd0);
    chk("mid_rst_pr", 32'(WB_PR), 32'd0);
    chk("mid_rst_rob", 32'(WB_ROB_index), 32'd0);
    chk("mid_rst_ready", 32'(issue_ready), 32'd1);
    repeat (5) step();
    chk("post_rst_valid", 32'(WB_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_pipeline_v2.md
ALU_PIPELINE_V2 -- requirements
Module: alu_pipeline_v2

Interface
REQ-001 SHALL use parameter PRF_BANK_COUNT, default 4: number of PRF banks; LOG_PRF_BANK_COUNT = 2.
REQ-002 SHALL use parameter PR_COUNT, default 64: number of physical registers; LOG_PR_COUNT = 6.
REQ-003 SHALL use parameter ROB_ENTRIES, default 64: number of ROB entries; LOG_ROB_ENTRIES = 6.
REQ-004 CLK  in  1  single clock; all state updates on the rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 issue_valid  in  1  an op is presented by the ALU issue queue.
REQ-007 issue_op  in  4  operation code, per REQ-017.
REQ-008 issue_is_imm  in  1  operand B is issue_imm, not a register.
REQ-009 issue_imm  in  32  immediate value.
REQ-010 issue_A_unneeded  in  1  operand A is unused; treat it as 0.
REQ-011 issue_A_forward / issue_B_forward  in  1 each  operand comes from the forward bus, not a reg read.
REQ-012 issue_A_bank / issue_B_bank  in  LOG_PRF_BANK_COUNT each  PRF bank of the operand.
REQ-013 issue_dest_PR  in  LOG_PR_COUNT; issue_ROB_index  in  LOG_ROB_ENTRIES  destination tags.
REQ-014 A_reg_read_valid / B_reg_read_valid  in  1 each; reg_read_data_by_bank  in  PRF_BANK_COUNT x 32  reg-read data for the op in OC.
REQ-015 forward_data_by_bank  in  PRF_BANK_COUNT x 32  forward data per bank.
REQ-016 issue_ready  out  1; WB_valid  out  1; WB_data  out  32; WB_PR  out  LOG_PR_COUNT; WB_ROB_index  out  LOG_ROB_ENTRIES; WB_ready  in  1  PRF accepts the writeback.

Function
REQ-017 Ops (result on A, B'; B' = imm if is_imm else B):
- 0000 ADD
- 0001 SLL, shift by B'[4:0]
- 0010 SLT (signed), 0011 SLTU; result is 1 or 0
- 0100 XOR
- 0101 SRL
- 0110 OR
- 0111 AND
- 1000 SUB
- 1101 SRA
- 1111 pass B'
- any other op[3]=1 code behaves as its op[2:0] op
REQ-018 There are 4 stages: issue -> OC (operand collect) -> EX -> WB, each with one valid-tagged register.
REQ-019 The op is accepted into OC on the edge where issue_valid && issue_ready.
REQ-020 issue_ready = !OC_valid || OC_advance.
- Ready is combinational, with no dependence on issue_valid.
REQ-021 OC collection of A: A is needed unless A_unneeded.
- If forwarded, A is captured from forward_data_by_bank[A_bank] in the first OC cycle.
- Otherwise A is captured from reg_read_data_by_bank[A_bank] in any OC cycle with A_reg_read_valid.
REQ-022 OC collection of B: B is needed unless is_imm, and is collected the same way as A.
REQ-023 Collected operands are saved across stall cycles.
REQ-024 OC_advance = every needed operand is collected (saved or arriving this cycle) && EX can accept.
REQ-025 EX can accept when it is empty or advancing.
- EX advances when WB is empty or WB_ready.
- The ALU result is computed combinationally in EX and registered into WB.
REQ-026 WB_valid is high while the WB register holds an op.
- The WB register holds its op while WB_valid && !WB_ready.
- It is cleared or replaced when WB_ready is high.
REQ-027 WB_data, WB_PR and WB_ROB_index update only when a valid op enters WB; otherwise they hold their last value.
REQ-028 Latency with no stalls: issue at edge N, EX during cycle N+1, WB_valid during cycle N+2 -> N+3.
- Throughput is one op per cycle.
REQ-029 Back-pressure rules:
- A held WB stalls EX, then OC, then drops issue_ready.
- Ops are never lost or duplicated.
- Ops stay in order.
REQ-030 Arithmetic is 32-bit modulo 2^32.

Reset
REQ-031 On a clock edge with RST high, all stage valid bits, saved-operand flags and output registers clear to 0.
- After reset: issue_ready = 1, WB_valid = 0, WB_data = 0, WB_PR = 0, WB_ROB_index = 0.
REQ-032 Reset mid-operation discards every in-flight op without writeback.

Verification
REQ-033 Reset with idle inputs -> issue_ready = 1, WB outputs all 0; NOP cycles keep WB_valid = 0.
REQ-034 ADD p2 (ROB 0), A bank0, B bank1; reg read bank0 = 1, bank1 = 0 in OC; WB_ready = 1 -> WB_valid = 1 two cycles later, WB_data = 1, WB_PR = 2, WB_ROB_index = 0.
REQ-035 SLLI p4 (ROB 1) issued back-to-back after the ADD, A bank3 = 3, imm 4 -> WB_data = 0x30, WB_PR = 4, WB_ROB_index = 1, in the cycle after the ADD's writeback.
REQ-036 SLT p7 with A forwarded (bank1 forward = 0xFFFFFFFF) and B read (bank2 = 0) -> WB_data = 1; the SLTU variant -> 0.
REQ-037 Withhold B_reg_read_valid for 2 cycles -> OC stalls, issue_ready = 0 while a new op waits, and the result stays correct when the operand arrives.
REQ-038 WB_ready = 0 for 3 cycles with 3 ops in flight -> WB outputs hold, issue_ready drops, and all 3 results drain in order once WB_ready = 1.
